// File: rtl/uart_defs_pkg.sv
// ---------------------------------------------------------------------------
// uart_defs
//   Shared definitions for the UART TX arbitration path.
//   - ArbState_t : arbiter FSM states (idle / grant held / inter-owner gap)
//   - ARB_MAX_REQ: largest requester count the arbiter supports
// ---------------------------------------------------------------------------
package uart_defs;

  localparam int ARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } ArbState_t;

endpackage : uart_defs

// File: rtl/uart_rr_picker.sv
// ---------------------------------------------------------------------------
// uart_rr_picker
//   Combinational round-robin picker: returns the first requesting index at
//   or after i_ptr, wrapping modulo NUM_REQ.
//   Ports:
//     i_req     [NUM_REQ]  request vector
//     i_ptr     [IDX_W]    starting (highest priority) index, < NUM_REQ
//     o_winner  [IDX_W]    selected index (i_ptr when nothing requests)
//     o_any_req            at least one request is active
// ---------------------------------------------------------------------------
module uart_rr_picker
  import uart_defs::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [IDX_W-1:0]   o_winner,
  output logic               o_any_req
);

  // w_cand[k] is the requester index sitting k places after the pointer.
  logic [IDX_W-1:0]   w_cand [NUM_REQ];
  logic [NUM_REQ-1:0] w_cand_req;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] w_sum;
    // ptr < NUM_REQ and gi < NUM_REQ, so a single conditional subtract wraps.
    assign w_sum         = {1'b0, i_ptr} + (IDX_W+1)'(gi);
    assign w_cand[gi]    = (w_sum >= (IDX_W+1)'(NUM_REQ))
                         ? IDX_W'(w_sum - (IDX_W+1)'(NUM_REQ))
                         : w_sum[IDX_W-1:0];
    assign w_cand_req[gi] = i_req[w_cand[gi]];
  end

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    o_winner = i_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_cand_req[k]) begin
        o_winner = w_cand[k];
      end
    end
  end

  assign o_any_req = |i_req;

endmodule : uart_rr_picker

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Round-robin, burst-granular arbiter sharing one UART TX byte interface
//   between NUM_REQ requesters. Traffic is gated by the flow controller's
//   TX enable; a one-cycle gap separates successive owners.
//   Ports:
//     tck, rst_n                 clock, asynchronous active-low reset
//     req_valid_i/last_i [N]     per-requester beat valid / end of burst
//     req_data_i [N*DATA_W]      requester i at [i*DATA_W +: DATA_W]
//     req_ready_o [N]            beat accepted by the owner
//     tx_valid_o/data_o          beat to UART TX, tx_ready_i accepts it
//     tx_enable_i                flow-controller TX enable
//     grant_id_o                 current (or last) grant owner
//     busy_o                     high outside ARB_IDLE
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_defs::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                       tck,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic                       tx_valid_o,
  output logic [DATA_W-1:0]          tx_data_o,
  input  logic                       tx_ready_i,
  input  logic                       tx_enable_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  ArbState_t        r_state,    w_state_next;
  logic [IDX_W-1:0] r_rr_ptr,   w_rr_ptr_next;
  logic [IDX_W-1:0] r_grant_id, w_grant_id_next;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_next;

  logic [IDX_W-1:0]  w_pick_id;
  logic              w_any_req;
  logic [DATA_W-1:0] w_beat_data [NUM_REQ];
  logic [IDX_W-1:0]  w_rr_inc;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_xfer;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_req     (req_valid_i),
    .i_ptr     (r_rr_ptr),
    .o_winner  (w_pick_id),
    .o_any_req (w_any_req)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
    assign w_beat_data[gi] = req_data_i[gi*DATA_W +: DATA_W];
  end

  // Zero-latency data path: the owner's slice goes straight to the UART.
  assign tx_data_o  = w_beat_data[r_grant_id];
  assign grant_id_o = r_grant_id;
  assign busy_o     = (r_state != ARB_IDLE);

  assign w_rr_inc  = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + IDX_W'(1);
  assign w_cnt_inc = r_beat_cnt + CNT_W'(1);

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_rr_ptr   <= w_rr_ptr_next;
      r_grant_id <= w_grant_id_next;
      r_beat_cnt <= w_beat_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_rr_ptr_next   = r_rr_ptr;
    w_grant_id_next = r_grant_id;
    w_beat_cnt_next = r_beat_cnt;
    tx_valid_o      = 1'b0;
    req_ready_o     = '0;
    w_xfer          = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (w_any_req) begin
          w_grant_id_next = w_pick_id;
          w_beat_cnt_next = '0;
          w_state_next    = ARB_GRANT;
        end
      end

      ARB_GRANT: begin
        // With enable low everything is frozen; the grant stays locked even
        // if the owner drops valid, until last or the burst limit.
        tx_valid_o              = req_valid_i[r_grant_id] & tx_enable_i;
        req_ready_o[r_grant_id] = tx_ready_i & tx_enable_i;
        w_xfer                  = req_valid_i[r_grant_id] & tx_enable_i & tx_ready_i;
        if (w_xfer) begin
          w_beat_cnt_next = w_cnt_inc;
          if (req_last_i[r_grant_id] || (w_cnt_inc == CNT_W'(MAX_BURST))) begin
            w_rr_ptr_next = w_rr_inc;
            w_state_next  = ARB_GAP;
          end
        end
      end

      ARB_GAP: begin
        // Idle cycle so the flow controller sees RTS drop between owners.
        w_state_next = ARB_IDLE;
      end

      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8,
//   MAX_BURST=16): vector table, directed multi-cycle sequences and a
//   randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;
  localparam int IW = 2;

  logic            tck = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_last_i = '0;
  logic [N-1:0]    req_ready_o;
  logic            tx_valid_o;
  logic [DW-1:0]   tx_data_o;
  logic            tx_ready_i = 1'b0;
  logic            tx_enable_i = 1'b0;
  logic [IW-1:0]   grant_id_o;
  logic            busy_o;

  always #5 tck = ~tck;

  uart_tx_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .tck         (tck),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .tx_enable_i (tx_enable_i),
    .grant_id_o  (grant_id_o),
    .busy_o      (busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- requester BFMs: queues of {last, data} ----------------
  logic [8:0] bq [N][$];
  bit         presenting [N];
  bit         acc [N];
  int         p_valid = 100;
  int         p_rdy   = 100;
  int         p_en    = 100;
  bit         force_en_low = 1'b0;

  // ---------------- reference model (owner / gap / pointer) ---------------
  int m_owner = -1;
  int m_last_owner = 0;
  int m_ptr = 0;
  int m_cnt = 0;
  bit m_gap = 1'b0;

  // ---------------- observed activity logs --------------------------------
  int         gs_id [$];
  int         gs_cyc [$];
  int         run_len [$];
  logic [7:0] xfer_log [$];
  int         cyc = 0;
  bit         prev_busy = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic clear_logs();
    gs_id.delete();
    gs_cyc.delete();
    run_len.delete();
    xfer_log.delete();
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_gap = 1'b0;
    m_ptr = 0;
    m_last_owner = 0;
    m_cnt = 0;
  endtask

  task automatic bfm_clear();
    for (int i = 0; i < N; i++) begin
      bq[i].delete();
      presenting[i] = 1'b0;
      acc[i] = 1'b0;
    end
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bfm_clear();
    model_reset();
    prev_busy = 1'b0;
    prev_stall = 1'b0;
    repeat (2) @(posedge tck);
    @(negedge tck);
    rst_n = 1'b1;
  endtask

  task automatic push_burst(input int r, input int len, input logic [7:0] base, input bit with_last);
    logic [8:0] e;
    for (int b = 0; b < len; b++) begin
      e[7:0] = base + 8'(b);
      e[8]   = with_last && (b == len - 1);
      bq[r].push_back(e);
    end
  endtask

  // Compare DUT outputs with the model, log activity, then advance the model
  // to what the next clock edge must do.
  task automatic monitor_and_model();
    bit           exp_txv;
    logic [N-1:0] exp_rdy;
    exp_txv = (m_owner >= 0) && req_valid_i[m_owner] && tx_enable_i;
    exp_rdy = '0;
    if (m_owner >= 0 && tx_enable_i && tx_ready_i) exp_rdy[m_owner] = 1'b1;

    check("busy", busy_o, (m_owner >= 0) || m_gap);
    check("grant_id", grant_id_o, m_last_owner);
    check("tx_valid", tx_valid_o, exp_txv);
    check("req_ready", req_ready_o, exp_rdy);
    if (exp_txv) check("tx_data", tx_data_o, req_data_i[m_owner*DW +: DW]);
    if (prev_stall && tx_valid_o) check("data_stable", tx_data_o, prev_data);
    prev_stall = tx_valid_o && !tx_ready_i;
    prev_data  = tx_data_o;

    if (busy_o && !prev_busy) begin
      gs_id.push_back(int'(grant_id_o));
      gs_cyc.push_back(cyc);
      run_len.push_back(0);
    end
    prev_busy = busy_o;
    if (tx_valid_o && tx_ready_i) begin
      xfer_log.push_back(tx_data_o);
      if (run_len.size() > 0) run_len[run_len.size()-1]++;
    end
    for (int i = 0; i < N; i++) acc[i] = req_valid_i[i] && req_ready_o[i];

    if (m_owner >= 0) begin
      if (exp_txv && tx_ready_i) begin
        m_cnt++;
        if (req_last_i[m_owner] || m_cnt == MB) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_gap   = 1'b1;
        end
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (req_valid_i != '0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (req_valid_i[idx]) begin
          m_owner = idx;
          m_last_owner = idx;
          m_cnt = 0;
          break;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [8:0] hb;
    @(posedge tck);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        void'(bq[i].pop_front());
        presenting[i] = 1'b0;
        acc[i] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!presenting[i] && bq[i].size() > 0 && $urandom_range(99) < p_valid) presenting[i] = 1'b1;
      req_valid_i[i] = presenting[i];
      if (presenting[i]) begin
        hb = bq[i][0];
        req_data_i[i*DW +: DW] = hb[7:0];
        req_last_i[i] = hb[8];
      end else begin
        req_data_i[i*DW +: DW] = 8'($urandom);
        req_last_i[i] = 1'b0;
      end
    end
    tx_ready_i  = ($urandom_range(99) < p_rdy);
    tx_enable_i = !force_en_low && ($urandom_range(99) < p_en);
    @(negedge tck);
    monitor_and_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    logic [N-1:0]    last;
    logic            rdy;
    logic            en;
    logic            busy;
    logic            txv;
    logic [N-1:0]    ready;
    logic [IW-1:0]   gid;
    logic [DW-1:0]   txd;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    int n0;

    // Requester 2 alone sends A1..A3, then all four request (pointer at 3).
    vecs[0] = '{4'b0100, 32'hD3A1D1D0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00};
    vecs[1] = '{4'b0100, 32'hD3A1D1D0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA1};
    vecs[2] = '{4'b0100, 32'hD3A2D1D0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2};
    vecs[3] = '{4'b0100, 32'hD3A3D1D0, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA3};
    vecs[4] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 2'd2, 8'h00};
    vecs[5] = '{4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00};
    vecs[6] = '{4'b1111, 32'hD3C2D1D0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd2, 8'h00};
    vecs[7] = '{4'b1111, 32'hD3C2D1D0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 2'd3, 8'hD3};

    // Idle after reset for 20 cycles.
    do_reset();
    repeat (20) cycle();
    $display("seq idle: checks=%0d errors=%0d", checks, errors);

    // Table-driven single-requester burst and pointer advance.
    do_reset();
    for (int r = 0; r < 8; r++) begin
      @(posedge tck);
      #1;
      req_valid_i = vecs[r].valid;
      req_data_i  = vecs[r].data;
      req_last_i  = vecs[r].last;
      tx_ready_i  = vecs[r].rdy;
      tx_enable_i = vecs[r].en;
      @(negedge tck);
      check($sformatf("vec%0d busy", r), busy_o, vecs[r].busy);
      check($sformatf("vec%0d tx_valid", r), tx_valid_o, vecs[r].txv);
      check($sformatf("vec%0d req_ready", r), req_ready_o, vecs[r].ready);
      check($sformatf("vec%0d grant_id", r), grant_id_o, vecs[r].gid);
      if (vecs[r].txv) check($sformatf("vec%0d tx_data", r), tx_data_o, vecs[r].txd);
      $display("vec %0d: busy=%0b txv=%0b rdy=%b gid=%0d data=%02h", r, busy_o, tx_valid_o, req_ready_o, grant_id_o, tx_data_o);
    end

    // All four continuously valid with 2-beat bursts.
    do_reset();
    clear_logs();
    for (int r = 0; r < N; r++)
      for (int b = 0; b < 4; b++) push_burst(r, 2, 8'(r*16 + b*2), 1'b1);
    repeat (40) cycle();
    check("rr_grant_count", gs_id.size() >= 5, 1);
    if (gs_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("rr_order%0d", k), gs_id[k], k % N);
        check($sformatf("rr_len%0d", k), run_len[k], 2);
        if (k > 0) check($sformatf("rr_spacing%0d", k), gs_cyc[k] - gs_cyc[k-1], 4);
      end
    end
    $display("seq round_robin: grants=%0d", gs_id.size());

    // Burst limit: requester 1 streams 40 beats without last.
    do_reset();
    clear_logs();
    push_burst(1, 40, 8'h40, 1'b0);
    cycle();
    push_burst(0, 3, 8'h10, 1'b1);
    repeat (120) cycle();
    check("maxb_grant_count", gs_id.size(), 4);
    if (gs_id.size() == 4) begin
      check("maxb_owner0", gs_id[0], 1);
      check("maxb_len0", run_len[0], 16);
      check("maxb_owner1", gs_id[1], 0);
      check("maxb_len1", run_len[1], 3);
      check("maxb_owner2", gs_id[2], 1);
      check("maxb_len2", run_len[2], 16);
      check("maxb_len3", run_len[3], 8);
    end
    $display("seq max_burst: beats=%0d", xfer_log.size());

    // TX enable dropped for 10 cycles after beat 2 of 5.
    do_reset();
    clear_logs();
    push_burst(0, 5, 8'hB1, 1'b1);
    guard = 0;
    while (xfer_log.size() < 2 && guard < 50) begin
      cycle();
      guard++;
    end
    check("en_pre_beats", xfer_log.size(), 2);
    force_en_low = 1'b1;
    n0 = xfer_log.size();
    repeat (10) cycle();
    check("en_low_xfers", xfer_log.size() - n0, 0);
    check("en_low_busy", busy_o, 1);
    force_en_low = 1'b0;
    repeat (10) cycle();
    check("en_total_beats", xfer_log.size(), 5);
    if (xfer_log.size() == 5)
      for (int k = 0; k < 5; k++) check($sformatf("en_beat%0d", k), xfer_log[k], 8'hB1 + k);
    check("en_one_grant", gs_id.size(), 1);
    $display("seq enable_drop: beats=%0d", xfer_log.size());

    // Asynchronous reset after beat 1 of a 4-beat burst.
    do_reset();
    clear_logs();
    push_burst(2, 1, 8'h77, 1'b1);
    repeat (5) cycle();
    push_burst(1, 4, 8'h61, 1'b1);
    guard = 0;
    while (xfer_log.size() < 2 && guard < 50) begin
      cycle();
      guard++;
    end
    check("rst_pre_beats", xfer_log.size(), 2);
    @(posedge tck);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_tx_valid", tx_valid_o, 0);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_grant_id", grant_id_o, 0);
    do_reset();
    clear_logs();
    for (int r = 0; r < N; r++) push_burst(r, 1, 8'(8'hE0 + r), 1'b1);
    repeat (3) cycle();
    check("rst_next_grant_count", gs_id.size() >= 1, 1);
    if (gs_id.size() >= 1) check("rst_next_grant", gs_id[0], 0);
    $display("seq reset_mid_burst: first_grant=%0d", gs_id.size() > 0 ? gs_id[0] : -1);

    // Randomized traffic against the reference model.
    do_reset();
    clear_logs();
    p_valid = 60;
    p_rdy   = 70;
    p_en    = 90;
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < N; r++)
        if (bq[r].size() == 0) push_burst(r, $urandom_range(24, 1), 8'($urandom), $urandom_range(3) != 0);
      if (c == 2000) do_reset();
      cycle();
    end
    $display("seq random: beats=%0d grants=%0d", xfer_log.size(), gs_id.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_uart_tx_arbiter
